// File: rtl/counter_pkg.sv
// counter_pkg: shared types and constants for the counter_ud block.
// Holds the decoded per-cycle operation type, the sat_mode encodings and
// the request decoder used by both the counter and its checker.
package counter_pkg;

   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_LOAD = 2'd1,
      OP_INC  = 2'd2,
      OP_DEC  = 2'd3
   } cnt_op_t;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Load dominates; inc and dec together cancel into a hold.
   function automatic cnt_op_t decode_op(input logic load,
                                         input logic inc,
                                         input logic dec);
      cnt_op_t op;
      if (load) begin
         op = OP_LOAD;
      end else if (inc && !dec) begin
         op = OP_INC;
      end else if (dec && !inc) begin
         op = OP_DEC;
      end else begin
         op = OP_HOLD;
      end
      return op;
   endfunction

endpackage

// File: rtl/counter_ud_au.sv
// counter_ud_au: passive assertion checker for counter_ud.
// Only compiled when COUNTER_UD_ASSERTS_EN is defined; it observes every
// counter port and flags X values, range violations, wrong steps, wrong
// wrap/saturate results, wrong event pulses and wrong load results.
`ifdef COUNTER_UD_ASSERTS_EN
module counter_ud_au
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned MAX_VAL = (32'd2 ** WIDTH) - 32'd1,
   parameter int unsigned RST_VAL = 32'd0
) (
   input logic             clk,
   input logic             rst,
   input logic             inc,
   input logic             dec,
   input logic             load,
   input logic [WIDTH-1:0] load_val,
   input logic             sat_mode,
   input logic             clr_flags,
   input logic [WIDTH-1:0] cnt,
   input logic             at_max,
   input logic             at_min,
   input logic             ovf_p,
   input logic             udf_p,
   input logic             ovf_sticky,
   input logic             udf_sticky
);

   localparam logic [WIDTH-1:0] C_MAX_W  = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] C_RST_W  = WIDTH'(RST_VAL);
   localparam logic [WIDTH-1:0] C_ZERO_W = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] C_ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

   cnt_op_t          w_op;
   logic             w_ovf_evt;
   logic             w_udf_evt;
   logic [WIDTH-1:0] w_load_sat;

   assign w_op       = decode_op(load, inc, dec);
   assign w_ovf_evt  = (w_op == OP_INC) && (cnt == C_MAX_W);
   assign w_udf_evt  = (w_op == OP_DEC) && (cnt == C_ZERO_W);
   assign w_load_sat = (load_val > C_MAX_W) ? C_MAX_W : load_val;

   a_no_x: assert property (@(posedge clk) disable iff (rst)
      !$isunknown({cnt, at_max, at_min, ovf_p, udf_p, ovf_sticky, udf_sticky}))
      else $error("%m: X on counter outputs at %0t", $time);
   c_no_x: cover property (@(posedge clk) disable iff (rst)
      !$isunknown({cnt, ovf_sticky, udf_sticky}));

   a_range: assert property (@(posedge clk) disable iff (rst) cnt <= C_MAX_W)
      else $error("%m: cnt above MAX_VAL at %0t", $time);
   c_range: cover property (@(posedge clk) disable iff (rst) cnt == C_MAX_W);

   a_bounds: assert property (@(posedge clk) disable iff (rst)
      (at_max == (cnt == C_MAX_W)) && (at_min == (cnt == C_ZERO_W)))
      else $error("%m: at_max/at_min disagree with cnt at %0t", $time);
   c_bounds: cover property (@(posedge clk) disable iff (rst) at_min);

   a_rst_val: assert property (@(posedge clk) $fell(rst) |-> cnt == C_RST_W)
      else $error("%m: cnt not RST_VAL after reset at %0t", $time);
   c_rst_val: cover property (@(posedge clk) $fell(rst));

   a_step_up: assert property (@(posedge clk) disable iff (rst)
      (w_op == OP_INC && cnt != C_MAX_W) |=> cnt == $past(cnt) + C_ONE_W)
      else $error("%m: wrong increment at %0t", $time);
   c_step_up: cover property (@(posedge clk) disable iff (rst)
      w_op == OP_INC && cnt != C_MAX_W);

   a_step_dn: assert property (@(posedge clk) disable iff (rst)
      (w_op == OP_DEC && cnt != C_ZERO_W) |=> cnt == $past(cnt) - C_ONE_W)
      else $error("%m: wrong decrement at %0t", $time);
   c_step_dn: cover property (@(posedge clk) disable iff (rst)
      w_op == OP_DEC && cnt != C_ZERO_W);

   a_ovf_val: assert property (@(posedge clk) disable iff (rst)
      w_ovf_evt |=> cnt == (($past(sat_mode) == MODE_SAT) ? C_MAX_W : C_ZERO_W))
      else $error("%m: wrong overflow result at %0t", $time);
   c_ovf_val: cover property (@(posedge clk) disable iff (rst) w_ovf_evt);

   a_udf_val: assert property (@(posedge clk) disable iff (rst)
      w_udf_evt |=> cnt == (($past(sat_mode) == MODE_SAT) ? C_ZERO_W : C_MAX_W))
      else $error("%m: wrong underflow result at %0t", $time);
   c_udf_val: cover property (@(posedge clk) disable iff (rst) w_udf_evt);

   a_ovf_p: assert property (@(posedge clk) disable iff (rst)
      ##1 (ovf_p == $past(w_ovf_evt)) && (ovf_sticky == ($past(w_ovf_evt) ||
          ($past(ovf_sticky) && !$past(clr_flags)))))
      else $error("%m: wrong ovf_p/ovf_sticky at %0t", $time);
   c_ovf_p: cover property (@(posedge clk) disable iff (rst) ovf_p ##1 !ovf_p);

   a_udf_p: assert property (@(posedge clk) disable iff (rst)
      ##1 (udf_p == $past(w_udf_evt)) && (udf_sticky == ($past(w_udf_evt) ||
          ($past(udf_sticky) && !$past(clr_flags)))))
      else $error("%m: wrong udf_p/udf_sticky at %0t", $time);
   c_udf_p: cover property (@(posedge clk) disable iff (rst) udf_p ##1 !udf_p);

   a_load: assert property (@(posedge clk) disable iff (rst)
      load |=> cnt == $past(w_load_sat))
      else $error("%m: wrong load result at %0t", $time);
   c_load: cover property (@(posedge clk) disable iff (rst) load);

endmodule
`endif

// File: rtl/counter_ud.sv
// counter_ud: parametrised up/down counter with parallel load, runtime
// wrap/saturate mode and overflow/underflow pulse and sticky flags.
// Optional checker: define COUNTER_UD_ASSERTS_EN to bind counter_ud_au.
module counter_ud
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned MAX_VAL = (32'd2 ** WIDTH) - 32'd1,
   parameter int unsigned RST_VAL = 32'd0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             sat_mode,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] cnt,
   output logic             at_max,
   output logic             at_min,
   output logic             ovf_p,
   output logic             udf_p,
   output logic             ovf_sticky,
   output logic             udf_sticky
);

   localparam logic [WIDTH-1:0] C_MAX_W = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] C_RST_W = WIDTH'(RST_VAL);
   localparam logic [WIDTH:0]   C_MAX   = {1'b0, C_MAX_W};
   localparam logic [WIDTH:0]   C_ZERO  = {(WIDTH+1){1'b0}};
   localparam logic [WIDTH:0]   C_ONE   = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_cnt;
   logic             r_ovf_p;
   logic             r_udf_p;
   logic             r_ovf_sticky;
   logic             r_udf_sticky;

   cnt_op_t          w_op;
   logic [WIDTH:0]   w_cnt_ext;
   logic [WIDTH:0]   w_load_ext;
   logic [WIDTH:0]   w_nxt;
   logic             w_ovf;
   logic             w_udf;

   assign w_op       = decode_op(load, inc, dec);
   assign w_cnt_ext  = {1'b0, r_cnt};
   assign w_load_ext = {1'b0, load_val};

   // Next-count and event decode; wrap targets are 0 / MAX_VAL, not 2**WIDTH-1.
   always_comb begin
      w_nxt = w_cnt_ext;
      w_ovf = 1'b0;
      w_udf = 1'b0;
      case (w_op)
         OP_LOAD: begin
            if (w_load_ext > C_MAX) begin
               w_nxt = C_MAX;
            end else begin
               w_nxt = w_load_ext;
            end
         end
         OP_INC: begin
            if (w_cnt_ext < C_MAX) begin
               w_nxt = w_cnt_ext + C_ONE;
            end else begin
               w_ovf = 1'b1;
               w_nxt = (sat_mode == MODE_SAT) ? C_MAX : C_ZERO;
            end
         end
         OP_DEC: begin
            if (w_cnt_ext != C_ZERO) begin
               w_nxt = w_cnt_ext - C_ONE;
            end else begin
               w_udf = 1'b1;
               w_nxt = (sat_mode == MODE_WRAP) ? C_MAX : C_ZERO;
            end
         end
         default: begin
            w_nxt = w_cnt_ext;
         end
      endcase
   end

   // Count register and event flags; a new event beats a same-cycle clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt        <= C_RST_W;
         r_ovf_p      <= 1'b0;
         r_udf_p      <= 1'b0;
         r_ovf_sticky <= 1'b0;
         r_udf_sticky <= 1'b0;
      end else begin
         // Final clamp keeps cnt in range even if the decode were ever wrong.
         r_cnt        <= (w_nxt > C_MAX) ? C_MAX_W : w_nxt[WIDTH-1:0];
         r_ovf_p      <= w_ovf;
         r_udf_p      <= w_udf;
         r_ovf_sticky <= w_ovf | (r_ovf_sticky & ~clr_flags);
         r_udf_sticky <= w_udf | (r_udf_sticky & ~clr_flags);
      end
   end

   assign cnt        = r_cnt;
   assign at_max     = (r_cnt == C_MAX_W);
   assign at_min     = (r_cnt == {WIDTH{1'b0}});
   assign ovf_p      = r_ovf_p;
   assign udf_p      = r_udf_p;
   assign ovf_sticky = r_ovf_sticky;
   assign udf_sticky = r_udf_sticky;

`ifdef COUNTER_UD_ASSERTS_EN
   counter_ud_au #(
      .WIDTH   (WIDTH),
      .MAX_VAL (MAX_VAL),
      .RST_VAL (RST_VAL)
   ) u_au (
      .clk        (clk),
      .rst        (rst),
      .inc        (inc),
      .dec        (dec),
      .load       (load),
      .load_val   (load_val),
      .sat_mode   (sat_mode),
      .clr_flags  (clr_flags),
      .cnt        (r_cnt),
      .at_max     (at_max),
      .at_min     (at_min),
      .ovf_p      (r_ovf_p),
      .udf_p      (r_udf_p),
      .ovf_sticky (r_ovf_sticky),
      .udf_sticky (r_udf_sticky)
   );
`else
   // Checker not built; the counter behaves identically.
`endif

endmodule

// File: tb/tb_counter_ud.sv
// tb_counter_ud: directed table-driven bench for counter_ud.
// DUT A: WIDTH=8, MAX_VAL=255, RST_VAL=5.  DUT B: WIDTH=8, MAX_VAL=9, RST_VAL=0.
module tb_counter_ud;

   typedef struct {
      logic       inc;
      logic       dec;
      logic       load;
      logic [7:0] lv;
      logic       sat;
      logic       clr;
      logic [7:0] cnt;
      logic       ovf;
      logic       udf;
      logic       ovfs;
      logic       udfs;
      logic       amax;
      logic       amin;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic       a_inc, a_dec, a_load, a_sat, a_clr;
   logic [7:0] a_lv, a_cnt;
   logic       a_max, a_min, a_ovf, a_udf, a_ovfs, a_udfs;
   logic       b_inc, b_dec, b_load, b_sat, b_clr;
   logic [7:0] b_lv, b_cnt;
   logic       b_max, b_min, b_ovf, b_udf, b_ovfs, b_udfs;

   int n_checks = 0;
   int n_pass   = 0;

   vec_t tab_a[17];
   vec_t tab_b[14];

   always #5 clk = ~clk;

   counter_ud #(.WIDTH(8), .MAX_VAL(255), .RST_VAL(5)) dut_a (
      .clk(clk), .rst(rst), .inc(a_inc), .dec(a_dec), .load(a_load),
      .load_val(a_lv), .sat_mode(a_sat), .clr_flags(a_clr), .cnt(a_cnt),
      .at_max(a_max), .at_min(a_min), .ovf_p(a_ovf), .udf_p(a_udf),
      .ovf_sticky(a_ovfs), .udf_sticky(a_udfs)
   );

   counter_ud #(.WIDTH(8), .MAX_VAL(9), .RST_VAL(0)) dut_b (
      .clk(clk), .rst(rst), .inc(b_inc), .dec(b_dec), .load(b_load),
      .load_val(b_lv), .sat_mode(b_sat), .clr_flags(b_clr), .cnt(b_cnt),
      .at_max(b_max), .at_min(b_min), .ovf_p(b_ovf), .udf_p(b_udf),
      .ovf_sticky(b_ovfs), .udf_sticky(b_udfs)
   );

   function automatic vec_t mk(input logic inc, input logic dec, input logic load,
                               input logic [7:0] lv, input logic sat, input logic clr,
                               input logic [7:0] cnt, input logic ovf, input logic udf,
                               input logic ovfs, input logic udfs,
                               input logic amax, input logic amin);
      vec_t v;
      v.inc = inc;  v.dec = dec;  v.load = load; v.lv = lv;
      v.sat = sat;  v.clr = clr;  v.cnt = cnt;   v.ovf = ovf;
      v.udf = udf;  v.ovfs = ovfs; v.udfs = udfs;
      v.amax = amax; v.amin = amin;
      return v;
   endfunction

   task automatic cmp(input string nm, input int idx,
                      input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", nm, idx, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      a_inc = 1'b0; a_dec = 1'b0; a_load = 1'b0; a_lv = 8'd0; a_sat = 1'b0; a_clr = 1'b0;
      b_inc = 1'b0; b_dec = 1'b0; b_load = 1'b0; b_lv = 8'd0; b_sat = 1'b0; b_clr = 1'b0;
   endtask

   // Drive one vector at the falling edge, clock it in, compare at the next falling edge.
   task automatic run_vec(input int sel, input int idx, input vec_t v);
      idle_inputs();
      if (sel == 0) begin
         a_inc = v.inc; a_dec = v.dec; a_load = v.load; a_lv = v.lv; a_sat = v.sat; a_clr = v.clr;
      end else begin
         b_inc = v.inc; b_dec = v.dec; b_load = v.load; b_lv = v.lv; b_sat = v.sat; b_clr = v.clr;
      end
      @(posedge clk);
      @(negedge clk);
      if (sel == 0) begin
         cmp("a_cnt", idx, a_cnt, v.cnt);
         cmp("a_ovf_p", idx, {7'd0, a_ovf}, {7'd0, v.ovf});
         cmp("a_udf_p", idx, {7'd0, a_udf}, {7'd0, v.udf});
         cmp("a_ovf_sticky", idx, {7'd0, a_ovfs}, {7'd0, v.ovfs});
         cmp("a_udf_sticky", idx, {7'd0, a_udfs}, {7'd0, v.udfs});
         cmp("a_at_max", idx, {7'd0, a_max}, {7'd0, v.amax});
         cmp("a_at_min", idx, {7'd0, a_min}, {7'd0, v.amin});
      end else begin
         cmp("b_cnt", idx, b_cnt, v.cnt);
         cmp("b_ovf_p", idx, {7'd0, b_ovf}, {7'd0, v.ovf});
         cmp("b_udf_p", idx, {7'd0, b_udf}, {7'd0, v.udf});
         cmp("b_ovf_sticky", idx, {7'd0, b_ovfs}, {7'd0, v.ovfs});
         cmp("b_udf_sticky", idx, {7'd0, b_udfs}, {7'd0, v.udfs});
         cmp("b_at_max", idx, {7'd0, b_max}, {7'd0, v.amax});
         cmp("b_at_min", idx, {7'd0, b_min}, {7'd0, v.amin});
      end
   endtask

   initial begin
      //              inc  dec  load lv      sat  clr  | cnt     ovf  udf  ovfs udfs max  min
      tab_a[0]  = mk(1'b0,1'b0,1'b0,8'd0,  1'b0,1'b0, 8'd5,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
      tab_a[1]  = mk(1'b0,1'b0,1'b1,8'd254,1'b0,1'b0, 8'd254,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
      tab_a[2]  = mk(1'b1,1'b0,1'b0,8'd0,  1'b0,1'b0, 8'd255,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0);
      tab_a[3]  = mk(1'b1,1'b0,1'b0,8'd0,  1'b0,1'b0, 8'd0,  1'b1,1'b0,1'b1,1'b0,1'b0,1'b1);
      tab_a[4]  = mk(1'b1,1'b0,1'b0,8'd0,  1'b0,1'b0, 8'd1,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0);
      tab_a[5]  = mk(1'b1,1'b0,1'b1,8'd3,  1'b0,1'b0, 8'd3,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0);
      tab_a[6]  = mk(1'b1,1'b1,1'b0,8'd0,  1'b0,1'b0, 8'd3,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0);
      tab_a[7]  = mk(1'b0,1'b1,1'b0,8'd0,  1'b0,1'b0, 8'd2,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0);
      tab_a[8]  = mk(1'b0,1'b1,1'b0,8'd0,  1'b0,1'b0, 8'd1,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0);
      tab_a[9]  = mk(1'b0,1'b1,1'b0,8'd0,  1'b0,1'b0, 8'd0,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b1);
      tab_a[10] = mk(1'b0,1'b1,1'b0,8'd0,  1'b0,1'b0, 8'd255,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0);
      tab_a[11] = mk(1'b0,1'b0,1'b0,8'd0,  1'b0,1'b1, 8'd255,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0);
      tab_a[12] = mk(1'b0,1'b0,1'b1,8'd0,  1'b0,1'b0, 8'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b1);
      tab_a[13] = mk(1'b0,1'b1,1'b0,8'd0,  1'b1,1'b1, 8'd0,  1'b0,1'b1,1'b0,1'b1,1'b0,1'b1);
      tab_a[14] = mk(1'b0,1'b0,1'b0,8'd0,  1'b0,1'b1, 8'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b1);
      tab_a[15] = mk(1'b0,1'b0,1'b1,8'd255,1'b1,1'b0, 8'd255,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0);
      tab_a[16] = mk(1'b1,1'b0,1'b0,8'd0,  1'b1,1'b0, 8'd255,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0);

      tab_b[0]  = mk(1'b0,1'b0,1'b1,8'd9,  1'b0,1'b0, 8'd9,  1'b0,1'b0,1'b0,1'b0,1'b1,1'b0);
      tab_b[1]  = mk(1'b1,1'b0,1'b0,8'd0,  1'b1,1'b0, 8'd9,  1'b1,1'b0,1'b1,1'b0,1'b1,1'b0);
      tab_b[2]  = mk(1'b1,1'b0,1'b0,8'd0,  1'b1,1'b0, 8'd9,  1'b1,1'b0,1'b1,1'b0,1'b1,1'b0);
      tab_b[3]  = mk(1'b0,1'b0,1'b0,8'd0,  1'b1,1'b0, 8'd9,  1'b0,1'b0,1'b1,1'b0,1'b1,1'b0);
      tab_b[4]  = mk(1'b0,1'b0,1'b1,8'd0,  1'b0,1'b0, 8'd0,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b1);
      tab_b[5]  = mk(1'b0,1'b1,1'b0,8'd0,  1'b0,1'b0, 8'd9,  1'b0,1'b1,1'b1,1'b1,1'b1,1'b0);
      tab_b[6]  = mk(1'b0,1'b0,1'b1,8'd4,  1'b0,1'b0, 8'd4,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b0);
      tab_b[7]  = mk(1'b1,1'b1,1'b0,8'd0,  1'b0,1'b0, 8'd4,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b0);
      tab_b[8]  = mk(1'b1,1'b0,1'b1,8'd200,1'b0,1'b0, 8'd9,  1'b0,1'b0,1'b1,1'b1,1'b1,1'b0);
      tab_b[9]  = mk(1'b1,1'b0,1'b0,8'd0,  1'b0,1'b0, 8'd0,  1'b1,1'b0,1'b1,1'b1,1'b0,1'b1);
      tab_b[10] = mk(1'b0,1'b1,1'b0,8'd0,  1'b1,1'b0, 8'd0,  1'b0,1'b1,1'b1,1'b1,1'b0,1'b1);
      tab_b[11] = mk(1'b1,1'b0,1'b1,8'd8,  1'b0,1'b0, 8'd8,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b0);
      tab_b[12] = mk(1'b1,1'b0,1'b0,8'd0,  1'b0,1'b0, 8'd9,  1'b0,1'b0,1'b1,1'b1,1'b1,1'b0);
      tab_b[13] = mk(1'b0,1'b1,1'b0,8'd0,  1'b0,1'b0, 8'd8,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b0);

      idle_inputs();

      // Power-on reset: values appear without any clock edge.
      #1 rst = 1'b1;
      #1;
      cmp("rst_a_cnt", 0, a_cnt, 8'd5);
      cmp("rst_a_flags", 0, {4'd0, a_ovf, a_udf, a_ovfs, a_udfs}, 8'd0);
      cmp("rst_b_cnt", 0, b_cnt, 8'd0);
      cmp("rst_b_flags", 0, {4'd0, b_ovf, b_udf, b_ovfs, b_udfs}, 8'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         run_vec(0, i, tab_a[i]);
      end
      for (int i = 0; i < 14; i++) begin
         run_vec(1, i, tab_b[i]);
      end

      // Mid-operation reset: set ovf_sticky on A, then reset with a load pending.
      idle_inputs();
      a_load = 1'b1; a_lv = 8'd255;
      @(posedge clk);
      @(negedge clk);
      a_load = 1'b0; a_inc = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmp("mid_pre_cnt", 0, a_cnt, 8'd0);
      cmp("mid_pre_ovfs", 0, {7'd0, a_ovfs}, 8'd1);
      a_inc = 1'b0; a_load = 1'b1; a_lv = 8'd77;
      #2 rst = 1'b1;
      #1;
      cmp("mid_rst_cnt", 0, a_cnt, 8'd5);
      cmp("mid_rst_flags", 0, {4'd0, a_ovf, a_udf, a_ovfs, a_udfs}, 8'd0);
      cmp("mid_rst_b_flags", 0, {4'd0, b_ovf, b_udf, b_ovfs, b_udfs}, 8'd0);
      @(posedge clk);
      @(negedge clk);
      cmp("mid_rst_load_blocked", 0, a_cnt, 8'd5);
      a_load = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cmp("post_rst_hold", 0, a_cnt, 8'd5);
      cmp("post_rst_b_cnt", 0, b_cnt, 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
